ddr_dmaster_bytes_to_packets: RTL and testbench

- Byte-stream-to-packet decoder in the DDR debug-master chain.
- Consumes raw 8-bit bytes from the transport FIFO.
- Strips SOP/EOP/channel/escape control codes and emits packetised bytes with channel, startofpacket and endofpacket.
- Feeds the downstream channel adapter directly.

---
 rtl/ddr_dmaster_st_pkg.sv | 9 +
 rtl/ddr_dmaster_st_out_reg.sv | 38 +++
 rtl/ddr_dmaster_bytes_to_packets.sv | 71 +++++++
 tb/tb_ddr_dmaster_bytes_to_packets.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ddr_dmaster_st_pkg.sv
// ddr_dmaster_st_pkg: control codes and stream-decoder state shared by the debug-master byte/packet converters
package ddr_dmaster_st_pkg;
  localparam logic [7:0] SOP_CODE = 8'h7A;
  localparam logic [7:0] EOP_CODE = 8'h7B;
  localparam logic [7:0] CHAN_CODE = 8'h7C;
  localparam logic [7:0] ESC_CODE = 8'h7D;
  localparam logic [7:0] ESC_XOR = 8'h20;
  typedef enum logic [1:0] {ST_NORMAL, ST_ESC, ST_CHAN, ST_CHAN_ESC} st_state_e;
endpackage

// File: rtl/ddr_dmaster_st_out_reg.sv
// ddr_dmaster_st_out_reg: single ready/valid register stage carrying data, channel and packet flags
module ddr_dmaster_st_out_reg #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [7:0]               load_data,
  input  logic [CHANNEL_WIDTH-1:0] load_channel,
  input  logic                     load_sop,
  input  logic                     load_eop,
  output logic                     in_ready,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_channel <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket <= 1'b0;
    end else if (in_ready) begin
      out_valid <= load;
      if (load) begin
        out_data <= load_data;
        out_channel <= load_channel;
        out_startofpacket <= load_sop;
        out_endofpacket <= load_eop;
      end
    end
  end
endmodule

// File: rtl/ddr_dmaster_bytes_to_packets.sv
// ddr_dmaster_bytes_to_packets: strips SOP/EOP/channel/escape codes from a byte stream into packet beats
module ddr_dmaster_bytes_to_packets
  import ddr_dmaster_st_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket
);
  st_state_e state, state_n;
  logic accept, norm, emit, set_sop, set_eop, ch_load, sop_pend, eop_pend;
  logic [7:0] emit_data, ch_val;
  logic [CHANNEL_WIDTH-1:0] channel;
  assign accept = in_valid && in_ready;
  // SOP/EOP/CHAN inside a channel sequence abort it and are decoded as in NORMAL
  assign norm = state == ST_NORMAL || (state == ST_CHAN && in_data inside {SOP_CODE, EOP_CODE, CHAN_CODE});
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_NORMAL;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (accept)
      state_n = norm ? (in_data == CHAN_CODE ? ST_CHAN : in_data == ESC_CODE ? ST_ESC : ST_NORMAL)
                     : (state == ST_CHAN && in_data == ESC_CODE) ? ST_CHAN_ESC : ST_NORMAL;
  end
  always_comb begin
    emit = accept && (state == ST_ESC || (norm && !(in_data inside {SOP_CODE, EOP_CODE, CHAN_CODE, ESC_CODE})));
    emit_data = state == ST_ESC ? in_data ^ ESC_XOR : in_data;
    set_sop = accept && norm && in_data == SOP_CODE;
    set_eop = accept && norm && in_data == EOP_CODE;
    ch_load = accept && (state == ST_CHAN_ESC || (state == ST_CHAN && !norm && in_data != ESC_CODE));
    ch_val = state == ST_CHAN_ESC ? in_data ^ ESC_XOR : in_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sop_pend <= 1'b0;
      eop_pend <= 1'b0;
      channel <= '0;
    end else begin
      sop_pend <= emit ? 1'b0 : sop_pend | set_sop;
      eop_pend <= emit ? 1'b0 : eop_pend | set_eop;
      if (ch_load) channel <= CHANNEL_WIDTH'(ch_val);
    end
  end
  ddr_dmaster_st_out_reg #(.CHANNEL_WIDTH(CHANNEL_WIDTH)) u_out (
    .clk(clk),
    .reset(reset),
    .load(emit),
    .load_data(emit_data),
    .load_channel(channel),
    .load_sop(sop_pend),
    .load_eop(eop_pend),
    .in_ready(in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_channel(out_channel),
    .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket)
  );
endmodule

// File: tb/tb_ddr_dmaster_bytes_to_packets.sv
// tb_ddr_dmaster_bytes_to_packets: directed vector table, corner sequences and random scoreboard for the decoder
module tb_ddr_dmaster_bytes_to_packets;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_ready, out_valid, out_sop, out_eop;
  logic [7:0] out_data, out_channel;
  int tests = 0, fails = 0;

  ddr_dmaster_bytes_to_packets #(.CHANNEL_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_channel(out_channel),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic iv; logic [7:0] id; logic ev; logic [7:0] ed; logic [7:0] ech; logic es; logic ee;
  } vec_t;
  vec_t tbl[$];

  typedef struct {logic [7:0] d; logic [7:0] ch; logic s; logic e;} beat_t;
  beat_t exp_q[$];

  function automatic void add(logic iv, logic [7:0] id, logic ev, logic [7:0] ed, logic [7:0] ech, logic es, logic ee);
    tbl.push_back('{iv, id, ev, ed, ech, es, ee});
  endfunction

  task automatic check_beat(string name, logic v, logic [7:0] d, logic [7:0] ch, logic s, logic e, logic ir);
    tests++;
    if (out_valid !== v || in_ready !== ir || (v && (out_data !== d || out_channel !== ch || out_sop !== s || out_eop !== e))) begin
      fails++;
      $display("FAIL %s: got v=%b d=%h ch=%h sop=%b eop=%b ir=%b, want v=%b d=%h ch=%h sop=%b eop=%b ir=%b",
               name, out_valid, out_data, out_channel, out_sop, out_eop, in_ready, v, d, ch, s, e, ir);
    end
  endtask

  task automatic check_reset_outputs(string name);
    tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_channel !== 8'h00 || out_sop !== 1'b0 || out_eop !== 1'b0) begin
      fails++;
      $display("FAIL %s: got v=%b d=%h ch=%h sop=%b eop=%b, want all zero", name, out_valid, out_data, out_channel, out_sop, out_eop);
    end
  endtask

  task automatic step(logic iv, logic [7:0] id, logic ordy);
    @(posedge clk); #1;
    in_valid = iv; in_data = id; out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset_state");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Reference decoder: expresses the byte-level rules directly, one accepted byte at a time
  bit m_esc, m_chan, m_chan_esc, m_sop, m_eop;
  logic [7:0] m_ch;

  function automatic void model_reset();
    m_esc = 0; m_chan = 0; m_chan_esc = 0; m_sop = 0; m_eop = 0; m_ch = 8'h00;
    exp_q.delete();
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (m_esc) begin
      m_esc = 0;
      exp_q.push_back('{b ^ 8'h20, m_ch, m_sop, m_eop});
      m_sop = 0; m_eop = 0;
      return;
    end
    if (m_chan_esc) begin
      m_chan_esc = 0; m_ch = b ^ 8'h20;
      return;
    end
    if (m_chan) begin
      m_chan = 0;
      if (b == 8'h7D) begin m_chan_esc = 1; return; end
      if (b != 8'h7A && b != 8'h7B && b != 8'h7C) begin m_ch = b; return; end
    end
    case (b)
      8'h7A: m_sop = 1;
      8'h7B: m_eop = 1;
      8'h7C: m_chan = 1;
      8'h7D: m_esc = 1;
      default: begin
        exp_q.push_back('{b, m_ch, m_sop, m_eop});
        m_sop = 0; m_eop = 0;
      end
    endcase
  endfunction

  function automatic logic [7:0] rand_byte();
    return ($urandom_range(0, 1) == 0) ? 8'(8'h7A + $urandom_range(0, 3)) : 8'($urandom);
  endfunction

  initial begin
    beat_t b;
    // channel abort (channel 0 after reset)
    add(1,8'h7C,0,0,0,0,0); add(1,8'h7A,0,0,0,0,0); add(1,8'h55,0,0,0,0,0);
    add(0,8'h00,1,8'h55,8'h00,1,0); add(0,8'h00,0,0,0,0,0);
    // basic packet on channel 3
    add(1,8'h7A,0,0,0,0,0); add(1,8'h7C,0,0,0,0,0); add(1,8'h03,0,0,0,0,0); add(1,8'h11,0,0,0,0,0);
    add(1,8'h22,1,8'h11,8'h03,1,0); add(1,8'h7B,1,8'h22,8'h03,0,0); add(1,8'h33,0,0,0,0,0);
    add(0,8'h00,1,8'h33,8'h03,0,1); add(0,8'h00,0,0,0,0,0);
    // escaped data bytes
    add(1,8'h7A,0,0,0,0,0); add(1,8'h7D,0,0,0,0,0); add(1,8'h5A,0,0,0,0,0); add(1,8'h7D,1,8'h7A,8'h03,1,0);
    add(1,8'h5D,0,0,0,0,0); add(1,8'h7B,1,8'h7D,8'h03,0,0); add(1,8'h7D,0,0,0,0,0); add(1,8'h5B,0,0,0,0,0);
    add(0,8'h00,1,8'h7B,8'h03,0,1); add(0,8'h00,0,0,0,0,0);
    // escaped channel, single-byte packet
    add(1,8'h7C,0,0,0,0,0); add(1,8'h7D,0,0,0,0,0); add(1,8'h5C,0,0,0,0,0); add(1,8'h7A,0,0,0,0,0);
    add(1,8'h7B,0,0,0,0,0); add(1,8'h44,0,0,0,0,0); add(0,8'h00,1,8'h44,8'h7C,1,1); add(0,8'h00,0,0,0,0,0);

    repeat (2) @(posedge clk);
    do_reset();
    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].id, 1'b1);
      check_beat($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ech, tbl[i].es, tbl[i].ee, 1'b1);
    end

    // backpressure: output frozen, then one-cycle release drains and accepts together
    do_reset();
    step(1, 8'h7A, 1); step(1, 8'h11, 1);
    step(1, 8'h22, 0); check_beat("bp_hold0", 1, 8'h11, 8'h00, 1, 0, 0);
    step(1, 8'h22, 0); check_beat("bp_hold1", 1, 8'h11, 8'h00, 1, 0, 0);
    step(1, 8'h22, 1); check_beat("bp_release", 1, 8'h11, 8'h00, 1, 0, 1);
    step(0, 8'h00, 0); check_beat("bp_next", 1, 8'h22, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1); check_beat("bp_drain", 1, 8'h22, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1); check_beat("bp_empty", 0, 0, 0, 0, 0, 1);

    // reset in the middle of an escaped sequence
    do_reset();
    step(1, 8'h7A, 1); step(1, 8'h7C, 1); step(1, 8'h05, 1); step(1, 8'h7D, 1);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    step(0, 8'h00, 1); check_beat("post_reset_idle", 0, 0, 0, 0, 0, 1);
    step(1, 8'h66, 1); step(0, 8'h00, 1);
    check_beat("post_reset_data", 1, 8'h66, 8'h00, 0, 0, 1);

    // random traffic against the reference decoder
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, rand_byte(), $urandom_range(0, 3) != 0);
      tests++;
      if (in_ready !== (!out_valid || out_ready)) begin
        fails++;
        $display("FAIL rnd_in_ready: got %b want %b", in_ready, !out_valid || out_ready);
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL rnd_extra: got d=%h, want no output", out_data);
        end else begin
          b = exp_q.pop_front();
          if (out_data !== b.d || out_channel !== b.ch || out_sop !== b.s || out_eop !== b.e) begin
            fails++;
            $display("FAIL rnd_beat: got d=%h ch=%h sop=%b eop=%b, want d=%h ch=%h sop=%b eop=%b",
                     out_data, out_channel, out_sop, out_eop, b.d, b.ch, b.s, b.e);
          end
        end
      end
      if (in_valid && in_ready) model_byte(in_data);
    end
    for (int c = 0; c < 3; c++) begin
      step(0, 8'h00, 1);
      if (out_valid) begin
        tests++;
        b = exp_q.size() != 0 ? exp_q.pop_front() : '{8'hxx, 8'hxx, 1'bx, 1'bx};
        if (out_data !== b.d || out_channel !== b.ch || out_sop !== b.s || out_eop !== b.e) begin
          fails++;
          $display("FAIL rnd_tail: got d=%h ch=%h sop=%b eop=%b, want d=%h ch=%h sop=%b eop=%b",
                   out_data, out_channel, out_sop, out_eop, b.d, b.ch, b.s, b.e);
        end
      end
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rnd_missing: got %0d beats left undelivered, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
